// File: rtl/rbb_pkg.sv
// Shared types and constants for the multi-bank result batch buffer.
package rbb_pkg;

  // Read-side FSM: IDLE while nothing is committed, DRAIN while batches are pending
  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } rd_state_t;

  // Default slot count and the matching bank-pointer width
  localparam int DEF_NUM_BANKS = 2;
  localparam int BANK_W        = $clog2(DEF_NUM_BANKS);

endpackage

// File: rtl/rbb_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a 1-cycle registered read.
// Contents are deliberately not reset.
module rbb_sdp_ram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];
  logic [DATA_W-1:0] rdata_r;

  // Write port: store one line per enabled cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: registered output, data appears the cycle after re
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/rbb_multibank.sv
// Multi-bank result batch buffer: the PE array fills one bank while the
// write-back path drains the oldest committed bank.
module rbb_multibank
  import rbb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 4,
  parameter int DATA_WIDTH      = 512,
  parameter int NUM_BANKS       = 2**BANK_W,
  parameter int LINES_PER_BATCH = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_din,
  input  logic                           wr_commit,
  output logic                           wr_full,
  output logic                           request,
  input  logic                           rd_en,
  output logic [DATA_WIDTH-1:0]          rd_dout,
  output logic                           rd_valid,
  output logic                           rd_last,
  output logic [$clog2(NUM_BANKS+1)-1:0] fill_count,
  output logic                           wr_overflow
);

  localparam int PTR_W  = $clog2(NUM_BANKS);
  localparam int FILL_W = $clog2(NUM_BANKS + 1);
  localparam int RAM_AW = PTR_W + ADDR_WIDTH;

  rd_state_t             state_r;
  logic [NUM_BANKS-1:0]  committed_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_line_r;
  logic [FILL_W-1:0]     fill_count_r;
  logic [FILL_W-1:0]     fill_next_s;
  logic                  wr_full_r;
  logic                  wr_overflow_r;
  logic                  rd_valid_r;
  logic                  rd_last_r;
  logic                  wr_accept_s;
  logic                  commit_s;
  logic                  rd_accept_s;
  logic                  last_s;

  // A committed bank is never written; the fill bank is free whenever not full
  assign wr_accept_s = wr_en && !wr_full_r && !committed_r[wr_ptr_r] && reset_n;
  assign commit_s    = wr_commit && !wr_full_r;
  assign rd_accept_s = rd_en && (state_r == DRAIN) && committed_r[rd_ptr_r];
  assign last_s      = rd_accept_s && (rd_line_r == ADDR_WIDTH'(LINES_PER_BATCH - 1));

  // Next occupancy: a commit and a free in the same cycle cancel out
  always_comb begin
    fill_next_s = fill_count_r;
    if (commit_s && !last_s) begin
      fill_next_s = fill_count_r + FILL_W'(1);
    end else if (!commit_s && last_s) begin
      fill_next_s = fill_count_r - FILL_W'(1);
    end else begin
      fill_next_s = fill_count_r;
    end
  end

  // Bank bookkeeping, pointers, occupancy and output flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      committed_r   <= '0;
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      rd_line_r     <= '0;
      fill_count_r  <= '0;
      wr_full_r     <= 1'b0;
      wr_overflow_r <= 1'b0;
      rd_valid_r    <= 1'b0;
      rd_last_r     <= 1'b0;
    end else begin
      if (commit_s) begin
        committed_r[wr_ptr_r] <= 1'b1;
        wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
      end
      if (last_s) begin
        committed_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r              <= rd_ptr_r + PTR_W'(1);
      end
      if (rd_accept_s) begin
        rd_line_r <= last_s ? '0 : rd_line_r + ADDR_WIDTH'(1);
      end
      if ((wr_en || wr_commit) && wr_full_r) begin
        wr_overflow_r <= 1'b1;
      end
      fill_count_r <= fill_next_s;
      wr_full_r    <= (fill_next_s == FILL_W'(NUM_BANKS));
      rd_valid_r   <= rd_accept_s;
      rd_last_r    <= last_s;
    end
  end

  // Read FSM: drain while any committed batch is pending
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (fill_count_r != '0) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_s && (fill_next_s == '0)) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  rbb_sdp_ram #(
    .ADDR_W (RAM_AW),
    .DATA_W (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept_s),
    .waddr ({wr_ptr_r, wr_addr}),
    .wdata (wr_din),
    .re    (rd_accept_s),
    .raddr ({rd_ptr_r, rd_line_r}),
    .rdata (rd_dout)
  );

  assign wr_full     = wr_full_r;
  assign request     = (state_r == DRAIN);
  assign rd_valid    = rd_valid_r;
  assign rd_last     = rd_last_r;
  assign fill_count  = fill_count_r;
  assign wr_overflow = wr_overflow_r;

endmodule

// File: tb/tb_rbb_multibank.sv
// Self-checking bench for rbb_multibank: directed scenarios plus a random
// phase, all checked every cycle against a batch-level reference model.
module tb_rbb_multibank;

  localparam int AW  = 4;
  localparam int DW  = 512;
  localparam int NB  = 2;
  localparam int LPB = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_din = '0;
  logic          wr_commit = 1'b0;
  logic          wr_full;
  logic          request;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_dout;
  logic          rd_valid;
  logic          rd_last;
  logic [1:0]    fill_count;
  logic          wr_overflow;

  always #5 clk = ~clk;

  rbb_multibank #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .NUM_BANKS       (NB),
    .LINES_PER_BATCH (LPB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_din      (wr_din),
    .wr_commit   (wr_commit),
    .wr_full     (wr_full),
    .request     (request),
    .rd_en       (rd_en),
    .rd_dout     (rd_dout),
    .rd_valid    (rd_valid),
    .rd_last     (rd_last),
    .fill_count  (fill_count),
    .wr_overflow (wr_overflow)
  );

  int errors = 0;
  int checks = 0;
  int vcount = 0;
  int lcount = 0;

  // Reference model: line storage per slot, queue-style slot indices, occupancy
  logic [DW-1:0] m_mem [NB*LPB];
  logic [DW-1:0] m_data;
  int  m_fill = 0;
  int  m_wb   = 0;
  int  m_rb   = 0;
  int  m_line = 0;
  bit  m_req  = 1'b0;
  bit  m_ovf  = 1'b0;
  bit  m_valid = 1'b0;
  bit  m_last  = 1'b0;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic model_step(input bit we, input int wa, input logic [DW-1:0] d,
                            input bit wc, input bit re, input bit rn);
    bit full, acc, freed, cok;
    int nf;
    if (!rn) begin
      m_fill = 0; m_wb = 0; m_rb = 0; m_line = 0;
      m_req = 1'b0; m_ovf = 1'b0; m_valid = 1'b0; m_last = 1'b0;
    end else begin
      full  = (m_fill == NB);
      acc   = re && m_req;
      freed = 1'b0;
      cok   = 1'b0;
      if (acc) begin
        m_data  = m_mem[m_rb*LPB + m_line];
        m_valid = 1'b1;
        m_last  = (m_line == LPB - 1);
        if (m_last) begin
          m_line = 0;
          m_rb   = (m_rb + 1) % NB;
          freed  = 1'b1;
        end else begin
          m_line++;
        end
      end else begin
        m_valid = 1'b0;
        m_last  = 1'b0;
      end
      if (we) begin
        if (!full) m_mem[m_wb*LPB + wa] = d;
        else m_ovf = 1'b1;
      end
      if (wc) begin
        if (!full) cok = 1'b1;
        else m_ovf = 1'b1;
      end
      if (cok) m_wb = (m_wb + 1) % NB;
      nf = m_fill + int'(cok) - int'(freed);
      if (!m_req) m_req = (m_fill != 0);
      else if (freed && nf == 0) m_req = 1'b0;
      m_fill = nf;
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later
  task automatic cyc(input bit we, input int wa, input bit wc, input bit re, input bit rn = 1'b1);
    logic [DW-1:0] d;
    d = rand_line();
    wr_en = we; wr_addr = wa[AW-1:0]; wr_din = d; wr_commit = wc; rd_en = re; reset_n = rn;
    @(posedge clk);
    model_step(we, wa, d, wc, re, rn);
    #1;
    if (rd_valid) vcount++;
    if (rd_valid && rd_last) lcount++;
    check_eq("request", DW'(request), DW'(m_req));
    check_eq("fill_count", DW'(fill_count), DW'(m_fill));
    check_eq("wr_full", DW'(wr_full), DW'(m_fill == NB));
    check_eq("wr_overflow", DW'(wr_overflow), DW'(m_ovf));
    check_eq("rd_valid", DW'(rd_valid), DW'(m_valid));
    check_eq("rd_last", DW'(rd_last), DW'(m_last));
    if (m_valid) check_eq("rd_dout", rd_dout, m_data);
  endtask

  task automatic write_batch();
    for (int i = 0; i < LPB; i++) cyc(1'b1, i, 1'b0, 1'b0);
  endtask

  task automatic reads(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    int v0, l0, wl;
    bit we, wc, re, rn;

    // 1: reset, one batch, drain in order
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    check_eq("t1_reset_req", DW'(request), DW'(1'b0));
    write_batch();
    cyc(1'b0, 0, 1'b1, 1'b0);
    check_eq("t1_fill", DW'(fill_count), DW'(2'd1));
    cyc(1'b0, 0, 1'b0, 1'b0);
    check_eq("t1_req", DW'(request), DW'(1'b1));
    v0 = vcount; l0 = lcount;
    reads(LPB);
    check_eq("t1_valids", DW'(vcount - v0), DW'(LPB));
    check_eq("t1_lasts", DW'(lcount - l0), DW'(1));

    // 2: two commits fill both slots, third commit overflows
    write_batch(); cyc(1'b0, 0, 1'b1, 1'b0);
    write_batch(); cyc(1'b0, 0, 1'b1, 1'b0);
    check_eq("t2_full", DW'(wr_full), DW'(1'b1));
    cyc(1'b0, 0, 1'b1, 1'b0);
    check_eq("t2_ovf", DW'(wr_overflow), DW'(1'b1));
    check_eq("t2_fill", DW'(fill_count), DW'(2'd2));
    cyc(1'b1, 3, 1'b0, 1'b0);

    // 3: free and commit in the same cycle, full and non-full cases
    reads(LPB - 1);
    cyc(1'b0, 0, 1'b1, 1'b1);
    write_batch(); cyc(1'b0, 0, 1'b1, 1'b0);
    check_eq("t3_refill", DW'(fill_count), DW'(2'd2));
    reads(LPB);
    write_batch();
    reads(LPB - 1);
    cyc(1'b0, 0, 1'b1, 1'b1);
    check_eq("t3_fill_same", DW'(fill_count), DW'(2'd1));

    // 4: two batches drained back to back
    write_batch(); cyc(1'b0, 0, 1'b1, 1'b0);
    v0 = vcount; l0 = lcount;
    reads(2 * LPB);
    check_eq("t4_valids", DW'(vcount - v0), DW'(2 * LPB));
    check_eq("t4_lasts", DW'(lcount - l0), DW'(2));
    check_eq("t4_req_drop", DW'(request), DW'(1'b0));

    // 5: rd_en with nothing pending is ignored
    v0 = vcount;
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b0, 1'b1);
    check_eq("t5_no_valid", DW'(vcount - v0), DW'(0));
    write_batch(); cyc(1'b0, 0, 1'b1, 1'b0); cyc(1'b0, 0, 1'b0, 1'b0);
    reads(LPB);

    // 6: reset in the middle of a drain
    write_batch(); cyc(1'b0, 0, 1'b1, 1'b0);
    write_batch(); cyc(1'b0, 0, 1'b1, 1'b0);
    reads(8);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    check_eq("t6_req", DW'(request), DW'(1'b0));
    check_eq("t6_fill", DW'(fill_count), DW'(2'd0));
    check_eq("t6_full", DW'(wr_full), DW'(1'b0));
    write_batch(); cyc(1'b0, 0, 1'b1, 1'b0); cyc(1'b0, 0, 1'b0, 1'b0);
    reads(LPB);

    // Random phase: writer always fills a whole batch before committing
    wl = 0;
    for (int c = 0; c < 3000; c++) begin
      rn = ($urandom_range(0, 299) != 0);
      we = (wl < LPB) && ($urandom_range(0, 3) != 0);
      wc = (wl == LPB) && ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 2) != 0);
      if (!rn) begin
        we = 1'b0;
        wc = 1'b0;
      end
      if (m_fill != NB) begin
        if (we) wl++;
        if (wc) wl = 0;
      end
      cyc(we, (wl > 0 && we && m_fill != NB) ? wl - 1 : wl, wc, re, rn);
      if (!rn) wl = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
